// File: rtl/o_result_drain_pkg.sv
// Shared types and constants for the o_result_drain result path.
// Optional feature macro: O_RESULT_DRAIN_RELU_EN (clamp negative results to zero).
package o_result_drain_pkg;

    // Word width of results and biases. The drain's DataWidth parameter must match it.
    localparam int DRAIN_DATA_WIDTH = 32;

    // Drain controller states
    typedef enum logic [1:0] {
        LOAD_BIAS  = 2'd0,
        RUN        = 2'd1,
        DRAIN_WAIT = 2'd2
    } drain_state_t;

    // Two's-complement saturation limits
    localparam logic [DRAIN_DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DRAIN_DATA_WIDTH-1){1'b1}}};
    localparam logic [DRAIN_DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DRAIN_DATA_WIDTH-1){1'b0}}};

    // One queued result: frame-end marker plus processed data
    typedef struct packed {
        logic                        last;
        logic [DRAIN_DATA_WIDTH-1:0] data;
    } fifo_entry_t;

    localparam int FIFO_ENTRY_WIDTH = $bits(fifo_entry_t);

endpackage

// File: rtl/o_result_drain_fifo.sv
// result_fifo: synchronous first-word-fall-through FIFO with a registered head.
// The head register is refreshed from the array (registered read) or bypassed
// from the write data when the FIFO is empty, so the head never comes
// combinationally from push_data.
module result_fifo #(
    parameter int Width     = 33,
    parameter int Depth     = 4,
    parameter int AddrWidth = 2
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam logic [AddrWidth:0] CountFull = (AddrWidth+1)'(Depth);
    localparam logic [AddrWidth:0] CountOne  = (AddrWidth+1)'(1);

    logic [Width-1:0]     mem [Depth];
    logic [AddrWidth-1:0] wr_ptr_reg;
    logic [AddrWidth-1:0] rd_ptr_reg;
    logic [AddrWidth-1:0] rd_ptr_next;
    logic [AddrWidth:0]   count_reg;
    logic [Width-1:0]     head_reg;
    logic                 do_push;
    logic                 do_pop;

    assign full        = (count_reg == CountFull);
    assign empty       = (count_reg == '0);
    assign do_push     = push && !full;
    assign do_pop      = pop && !empty;
    assign rd_ptr_next = rd_ptr_reg + 1'b1;
    assign pop_data    = head_reg;

    // Storage array write port (no reset, so it maps onto RAM)
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers, occupancy and head register
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_next;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // Head follows the oldest remaining entry
            if (do_pop) begin
                if (count_reg > CountOne) begin
                    head_reg <= mem[rd_ptr_next];
                end else if (do_push) begin
                    head_reg <= push_data;
                end
            end else if (empty && do_push) begin
                head_reg <= push_data;
            end
        end
    end

endmodule

// File: rtl/o_result_drain.sv
// o_result_drain: adds per-channel bias to accumulated results, saturates,
// optionally applies ReLU, and queues results with a frame-end marker.
// Optional feature macro: O_RESULT_DRAIN_RELU_EN.
module o_result_drain
    import o_result_drain_pkg::*;
#(
    parameter int DataWidth       = DRAIN_DATA_WIDTH,
    parameter int O_PEGroupSize   = 4,
    parameter int O_PEAddrWidth   = 2,
    parameter int FifoDepth       = 4,
    parameter int FifoAddrWidth   = 2,
    parameter int FrameCountWidth = 16
) (
    input  logic                       clk,
    input  logic                       aclr,
    input  logic                       DataInValid,
    output logic                       DataInRdy,
    input  logic [DataWidth-1:0]       DataIn,
    input  logic                       Bias_Valid,
    output logic                       Bias_Rdy,
    input  logic [DataWidth-1:0]       Bias_In,
    input  logic                       Bias_Reload,
    output logic                       DataOutValid,
    input  logic                       DataOutRdy,
    output logic [DataWidth-1:0]       DataOut,
    output logic                       DataOutLast,
    output logic [FrameCountWidth-1:0] Frame_Count,
    output logic                       Sat_Flag
);

    localparam logic [O_PEAddrWidth-1:0] LastCh = O_PEAddrWidth'(O_PEGroupSize - 1);

    drain_state_t               state_reg;
    drain_state_t               state_next;
    logic [O_PEAddrWidth-1:0]   ch_reg;
    logic [O_PEAddrWidth-1:0]   ch_next;
    logic [O_PEAddrWidth-1:0]   bias_ptr_reg;
    logic                       reload_pend_reg;
    logic [DataWidth-1:0]       bias_reg [O_PEGroupSize];
    logic                       sat_flag_reg;
    logic [FrameCountWidth-1:0] frame_count_reg;

    logic                        fifo_full;
    logic                        fifo_empty;
    logic [FIFO_ENTRY_WIDTH-1:0] head_bits;
    fifo_entry_t                 head_entry;
    fifo_entry_t                 push_entry;

    logic                 bias_fire;
    logic                 data_fire;
    logic                 pop_fire;
    logic [DataWidth-1:0] bias_sel;
    logic [DataWidth:0]   sum_ext;
    logic                 sat_hi;
    logic                 sat_lo;
    logic [DataWidth-1:0] sat_val;
    logic [DataWidth-1:0] result;

    // Handshake readiness comes only from registered state
    assign DataInRdy    = (state_reg == RUN) && !fifo_full;
    assign Bias_Rdy     = (state_reg == LOAD_BIAS);
    assign DataOutValid = !fifo_empty;
    assign head_entry   = fifo_entry_t'(head_bits);
    assign DataOut      = head_entry.data;
    assign DataOutLast  = head_entry.last;
    assign Frame_Count  = frame_count_reg;
    assign Sat_Flag     = sat_flag_reg;

    assign bias_fire = Bias_Valid && Bias_Rdy;
    assign data_fire = DataInValid && DataInRdy;
    assign pop_fire  = DataOutValid && DataOutRdy;

    // Channel counter after this cycle's push, wrapping at the frame end
    always_comb begin
        ch_next = ch_reg;
        if (data_fire) begin
            ch_next = (ch_reg == LastCh) ? '0 : ch_reg + 1'b1;
        end
    end

    // Bias add in DataWidth+1 bits, clamp to signed range, optional ReLU
    always_comb begin
        bias_sel = bias_reg[ch_reg];
        sum_ext  = {DataIn[DataWidth-1], DataIn} + {bias_sel[DataWidth-1], bias_sel};
        sat_hi   = !sum_ext[DataWidth] && sum_ext[DataWidth-1];
        sat_lo   = sum_ext[DataWidth] && !sum_ext[DataWidth-1];
        if (sat_hi) begin
            sat_val = SAT_MAX;
        end else if (sat_lo) begin
            sat_val = SAT_MIN;
        end else begin
            sat_val = sum_ext[DataWidth-1:0];
        end
`ifdef O_RESULT_DRAIN_RELU_EN
        result = sat_val[DataWidth-1] ? '0 : sat_val;
`else
        result = sat_val;
`endif
        push_entry.last = (ch_reg == LastCh);
        push_entry.data = result;
    end

    // State register
    always_ff @(posedge clk) begin
        if (aclr) begin
            state_reg <= LOAD_BIAS;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a reload waits for the frame boundary, then for the FIFO to empty
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOAD_BIAS: begin
                if (bias_fire && (bias_ptr_reg == LastCh)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (reload_pend_reg && (ch_next == '0)) begin
                    state_next = DRAIN_WAIT;
                end
            end
            DRAIN_WAIT: begin
                if (fifo_empty) begin
                    state_next = LOAD_BIAS;
                end
            end
            default: state_next = LOAD_BIAS;
        endcase
    end

    // Channel, bias pointer, reload request, saturation flag and frame counter
    always_ff @(posedge clk) begin
        if (aclr) begin
            ch_reg          <= '0;
            bias_ptr_reg    <= '0;
            reload_pend_reg <= 1'b0;
            sat_flag_reg    <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            ch_reg <= ch_next;
            if (bias_fire) begin
                bias_ptr_reg <= (bias_ptr_reg == LastCh) ? '0 : bias_ptr_reg + 1'b1;
            end
            // A fresh request arriving on the drain-exit cycle is kept
            if ((state_reg == DRAIN_WAIT) && fifo_empty) begin
                reload_pend_reg <= Bias_Reload;
            end else if (Bias_Reload) begin
                reload_pend_reg <= 1'b1;
            end
            if (data_fire && (sat_hi || sat_lo)) begin
                sat_flag_reg <= 1'b1;
            end
            if (pop_fire && head_entry.last) begin
                frame_count_reg <= frame_count_reg + 1'b1;
            end
        end
    end

    // Per-channel bias registers, loaded in channel order
    generate
        for (genvar gi = 0; gi < O_PEGroupSize; gi++) begin : g_bias
            always_ff @(posedge clk) begin
                if (aclr) begin
                    bias_reg[gi] <= '0;
                end else if (bias_fire && (bias_ptr_reg == O_PEAddrWidth'(gi))) begin
                    bias_reg[gi] <= Bias_In;
                end
            end
        end
    endgenerate

    result_fifo #(
        .Width     (FIFO_ENTRY_WIDTH),
        .Depth     (FifoDepth),
        .AddrWidth (FifoAddrWidth)
    ) u_result_fifo (
        .clk       (clk),
        .srst      (aclr),
        .push      (data_fire),
        .push_data (push_entry),
        .pop       (pop_fire),
        .pop_data  (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_o_result_drain.sv
// Directed testbench for o_result_drain; honours O_RESULT_DRAIN_RELU_EN for expectations.
module tb_o_result_drain;

    logic        clk;
    logic        aclr;
    logic        DataInValid;
    logic        DataInRdy;
    logic [31:0] DataIn;
    logic        Bias_Valid;
    logic        Bias_Rdy;
    logic [31:0] Bias_In;
    logic        Bias_Reload;
    logic        DataOutValid;
    logic        DataOutRdy;
    logic [31:0] DataOut;
    logic        DataOutLast;
    logic [15:0] Frame_Count;
    logic        Sat_Flag;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] obs_data [$];
    logic        obs_last [$];

    o_result_drain dut (
        .clk          (clk),
        .aclr         (aclr),
        .DataInValid  (DataInValid),
        .DataInRdy    (DataInRdy),
        .DataIn       (DataIn),
        .Bias_Valid   (Bias_Valid),
        .Bias_Rdy     (Bias_Rdy),
        .Bias_In      (Bias_In),
        .Bias_Reload  (Bias_Reload),
        .DataOutValid (DataOutValid),
        .DataOutRdy   (DataOutRdy),
        .DataOut      (DataOut),
        .DataOutLast  (DataOutLast),
        .Frame_Count  (Frame_Count),
        .Sat_Flag     (Sat_Flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every pop, one line per transaction
    always @(negedge clk) begin
        if (!aclr && DataOutValid && DataOutRdy) begin
            obs_data.push_back(DataOut);
            obs_last.push_back(DataOutLast);
            $display("pop  data=%08h last=%0b frames_before=%0d", DataOut, DataOutLast, Frame_Count);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        aclr = 1'b1;
        DataInValid = 1'b0; DataIn = '0;
        Bias_Valid = 1'b0; Bias_In = '0; Bias_Reload = 1'b0;
        DataOutRdy = 1'b0;
        tick(2);
        aclr = 1'b0;
        obs_data.delete();
        obs_last.delete();
    endtask

    task automatic load_biases(input logic [31:0] b0, input logic [31:0] b1,
                               input logic [31:0] b2, input logic [31:0] b3);
        logic [31:0] b [4];
        b = '{b0, b1, b2, b3};
        for (int i = 0; i < 4; i++) begin
            int waited = 0;
            Bias_In = b[i]; Bias_Valid = 1'b1;
            while (Bias_Rdy !== 1'b1 && waited < 50) begin tick(1); waited++; end
            if (Bias_Rdy !== 1'b1) begin
                n_checks++;
                $display("FAIL bias_load: Bias_Rdy=%b, required 1 within 50 cycles", Bias_Rdy);
            end else begin
                tick(1);
                $display("bias ch=%0d value=%08h", i, b[i]);
            end
        end
        Bias_Valid = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d);
        int waited = 0;
        DataIn = d; DataInValid = 1'b1;
        while (DataInRdy !== 1'b1 && waited < 50) begin tick(1); waited++; end
        if (DataInRdy !== 1'b1) begin
            n_checks++;
            $display("FAIL push_timeout: DataInRdy=%b, required 1 within 50 cycles (data %08h)", DataInRdy, d);
        end else begin
            tick(1);
            $display("push data=%08h", d);
        end
        DataInValid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (DataInRdy !== 1'b0) $display("FAIL rst_datainrdy: got %b, required 0", DataInRdy); else n_pass++;
        n_checks++; if (Bias_Rdy !== 1'b1) $display("FAIL rst_biasrdy: got %b, required 1", Bias_Rdy); else n_pass++;
        n_checks++; if (DataOutValid !== 1'b0) $display("FAIL rst_outvalid: got %b, required 0", DataOutValid); else n_pass++;
        n_checks++; if (DataOut !== 32'd0) $display("FAIL rst_dataout: got %08h, required 0", DataOut); else n_pass++;
        n_checks++; if (DataOutLast !== 1'b0) $display("FAIL rst_last: got %b, required 0", DataOutLast); else n_pass++;
        n_checks++; if (Frame_Count !== 16'd0) $display("FAIL rst_frames: got %0d, required 0", Frame_Count); else n_pass++;
        n_checks++; if (Sat_Flag !== 1'b0) $display("FAIL rst_sat: got %b, required 0", Sat_Flag); else n_pass++;
    endtask

    task automatic test_basic();
        logic [31:0] exp_d [4];
        logic        exp_l [4];
        exp_d = '{32'd11, 32'd22, 32'd33, 32'd44};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        load_biases(32'd10, 32'd20, 32'd30, 32'd40);
        n_checks++; if (DataInRdy !== 1'b1) $display("FAIL basic_run_rdy: got %b, required 1", DataInRdy); else n_pass++;
        DataOutRdy = 1'b1;
        push_word(32'd1); push_word(32'd2); push_word(32'd3); push_word(32'd4);
        tick(4);
        n_checks++; if (obs_data.size() != 4) $display("FAIL basic_count: got %0d pops, required 4", obs_data.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a_d = (i < obs_data.size()) ? obs_data[i] : 32'hxxxxxxxx;
            logic        a_l = (i < obs_last.size()) ? obs_last[i] : 1'bx;
            n_checks++;
            if (a_d !== exp_d[i] || a_l !== exp_l[i])
                $display("FAIL basic_pop%0d: got %08h/last %b, required %08h/last %b", i, a_d, a_l, exp_d[i], exp_l[i]);
            else n_pass++;
        end
        n_checks++; if (Frame_Count !== 16'd1) $display("FAIL basic_frames: got %0d, required 1", Frame_Count); else n_pass++;
        n_checks++; if (Sat_Flag !== 1'b0) $display("FAIL basic_sat: got %b, required 0", Sat_Flag); else n_pass++;
        DataOutRdy = 1'b0;
    endtask

    task automatic test_saturation();
        logic [31:0] exp_d [4];
        logic        exp_l [4];
`ifdef O_RESULT_DRAIN_RELU_EN
        exp_d = '{32'h7FFFFFFF, 32'h00000000, 32'h00000000, 32'd7};
`else
        exp_d = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFB, 32'd7};
`endif
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        load_biases(32'd1, 32'hFFFFFFFF, 32'd0, 32'd0);
        DataOutRdy = 1'b1;
        n_checks++; if (Sat_Flag !== 1'b0) $display("FAIL sat_before: got %b, required 0", Sat_Flag); else n_pass++;
        push_word(32'h7FFFFFFF);
        n_checks++; if (Sat_Flag !== 1'b1) $display("FAIL sat_set: got %b, required 1", Sat_Flag); else n_pass++;
        push_word(32'h80000000); push_word(32'hFFFFFFFB); push_word(32'd7);
        tick(4);
        n_checks++; if (obs_data.size() != 4) $display("FAIL sat_count: got %0d pops, required 4", obs_data.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a_d = (i < obs_data.size()) ? obs_data[i] : 32'hxxxxxxxx;
            logic        a_l = (i < obs_last.size()) ? obs_last[i] : 1'bx;
            n_checks++;
            if (a_d !== exp_d[i] || a_l !== exp_l[i])
                $display("FAIL sat_pop%0d: got %08h/last %b, required %08h/last %b", i, a_d, a_l, exp_d[i], exp_l[i]);
            else n_pass++;
        end
        n_checks++; if (Sat_Flag !== 1'b1) $display("FAIL sat_sticky: got %b, required 1", Sat_Flag); else n_pass++;
        DataOutRdy = 1'b0;
    endtask

    task automatic test_back_pressure();
        logic [31:0] exp_d [4];
        exp_d = '{32'd15, 32'd26, 32'd37, 32'd48};
        do_reset();
        load_biases(32'd10, 32'd20, 32'd30, 32'd40);
        DataOutRdy = 1'b0;
        push_word(32'd5);
        n_checks++; if (DataOutValid !== 1'b1) $display("FAIL bp_latency_valid: got %b, required 1", DataOutValid); else n_pass++;
        n_checks++; if (DataOut !== 32'd15) $display("FAIL bp_latency_data: got %08h, required %08h", DataOut, 32'd15); else n_pass++;
        push_word(32'd6); push_word(32'd7);
        n_checks++; if (DataInRdy !== 1'b1) $display("FAIL bp_rdy_3: got %b, required 1", DataInRdy); else n_pass++;
        push_word(32'd8);
        n_checks++; if (DataInRdy !== 1'b0) $display("FAIL bp_rdy_full: got %b, required 0", DataInRdy); else n_pass++;
        tick(3);
        n_checks++; if (DataOut !== 32'd15) $display("FAIL bp_head_stable: got %08h, required %08h", DataOut, 32'd15); else n_pass++;
        n_checks++; if (obs_data.size() != 0) $display("FAIL bp_no_pop: got %0d pops, required 0", obs_data.size()); else n_pass++;
        DataOutRdy = 1'b1;
        tick(6);
        n_checks++; if (obs_data.size() != 4) $display("FAIL bp_count: got %0d pops, required 4", obs_data.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a_d = (i < obs_data.size()) ? obs_data[i] : 32'hxxxxxxxx;
            n_checks++;
            if (a_d !== exp_d[i]) $display("FAIL bp_pop%0d: got %08h, required %08h", i, a_d, exp_d[i]);
            else n_pass++;
        end
        n_checks++; if (DataInRdy !== 1'b1) $display("FAIL bp_rdy_after: got %b, required 1", DataInRdy); else n_pass++;
        n_checks++; if (Frame_Count !== 16'd1) $display("FAIL bp_frames: got %0d, required 1", Frame_Count); else n_pass++;
        DataOutRdy = 1'b0;
    endtask

    task automatic test_reload();
        logic [31:0] exp_d [8];
        int waited = 0;
        exp_d = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd101, 32'd202, 32'd303, 32'd404};
        do_reset();
        load_biases(32'd10, 32'd20, 32'd30, 32'd40);
        DataOutRdy = 1'b1;
        push_word(32'd1); push_word(32'd2);
        Bias_Reload = 1'b1; tick(1); Bias_Reload = 1'b0;
        n_checks++; if (DataInRdy !== 1'b1) $display("FAIL reload_midframe_rdy: got %b, required 1", DataInRdy); else n_pass++;
        push_word(32'd3); push_word(32'd4);
        n_checks++;
        if (DataInRdy !== 1'b0 || Bias_Rdy !== 1'b0)
            $display("FAIL reload_drain_wait: got DataInRdy=%b Bias_Rdy=%b, required 0/0", DataInRdy, Bias_Rdy);
        else n_pass++;
        while (Bias_Rdy !== 1'b1 && waited < 20) begin tick(1); waited++; end
        n_checks++; if (Bias_Rdy !== 1'b1) $display("FAIL reload_load_state: Bias_Rdy=%b, required 1", Bias_Rdy); else n_pass++;
        n_checks++; if (DataOutValid !== 1'b0) $display("FAIL reload_fifo_empty: got %b, required 0", DataOutValid); else n_pass++;
        load_biases(32'd100, 32'd200, 32'd300, 32'd400);
        push_word(32'd1); push_word(32'd2); push_word(32'd3); push_word(32'd4);
        tick(4);
        n_checks++; if (obs_data.size() != 8) $display("FAIL reload_count: got %0d pops, required 8", obs_data.size()); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a_d = (i < obs_data.size()) ? obs_data[i] : 32'hxxxxxxxx;
            n_checks++;
            if (a_d !== exp_d[i]) $display("FAIL reload_pop%0d: got %08h, required %08h", i, a_d, exp_d[i]);
            else n_pass++;
        end
        n_checks++; if (Frame_Count !== 16'd2) $display("FAIL reload_frames: got %0d, required 2", Frame_Count); else n_pass++;
        DataOutRdy = 1'b0;
    endtask

    task automatic test_aclr_midframe();
        do_reset();
        load_biases(32'd10, 32'd20, 32'd30, 32'd40);
        DataOutRdy = 1'b1;
        push_word(32'd1); push_word(32'd2); push_word(32'd3); push_word(32'd4);
        tick(4);
        DataOutRdy = 1'b0;
        push_word(32'd50); push_word(32'd60);
        n_checks++; if (Frame_Count !== 16'd1) $display("FAIL aclr_pre_frames: got %0d, required 1", Frame_Count); else n_pass++;
        aclr = 1'b1; tick(1);
        n_checks++; if (DataOutValid !== 1'b0) $display("FAIL aclr_outvalid: got %b, required 0", DataOutValid); else n_pass++;
        n_checks++; if (Frame_Count !== 16'd0) $display("FAIL aclr_frames: got %0d, required 0", Frame_Count); else n_pass++;
        n_checks++; if (Bias_Rdy !== 1'b1) $display("FAIL aclr_biasrdy: got %b, required 1", Bias_Rdy); else n_pass++;
        aclr = 1'b0;
        obs_data.delete(); obs_last.delete();
        load_biases(32'd0, 32'd0, 32'd0, 32'd0);
        DataOutRdy = 1'b1;
        push_word(32'd9);
        tick(4);
        n_checks++;
        if (obs_data.size() != 1 || obs_data[0] !== 32'd9 || obs_last[0] !== 1'b0)
            $display("FAIL aclr_no_stale: got %0d pops (first %08h), required 1 pop of 00000009", obs_data.size(),
                     (obs_data.size() > 0) ? obs_data[0] : 32'd0);
        else n_pass++;
        DataOutRdy = 1'b0;
    endtask

    initial begin
        aclr = 1'b1;
        DataInValid = 1'b0; DataIn = '0;
        Bias_Valid = 1'b0; Bias_In = '0; Bias_Reload = 1'b0;
        DataOutRdy = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_back_pressure();
        test_reload();
        test_aclr_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
